// File: rtl/sccb_arb_pkg.sv
// Shared definitions for the SCCB request arbiter: state encoding, the COM7
// soft-reset word and the default timing/queue parameters.
package sccb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [15:0] COM7_RESET = 16'h1280;

  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_SETTLE_CYCLES  = 50000;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sccb_req_fifo.sv
// Runtime write queue: FIFO of 16-bit {reg addr, value} words with first-word
// fall-through read data. A push is refused when full, even if popping.
module sccb_req_fifo
  import sccb_arb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] wdata,
  input  logic        pop,
  output logic [15:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sccb_request_arbiter.sv
// Arbitrates the init-table requester and the runtime write queue onto one
// SCCB write engine, with inter-transaction gap, COM7 settle and watchdog.
module sccb_request_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_call,
  input  logic [15:0] init_data,
  output logic        init_done,
  input  logic        usr_valid,
  input  logic [15:0] usr_data,
  output logic        usr_ready,
  output logic        usr_done,
  output logic        sccb_call,
  output logic [15:0] sccb_data,
  input  logic        sccb_done,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CNT_MAX = max3(GAP_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   word_q, word_d;
  logic          owner_q, owner_d;
  logic          call_q, call_d;
  logic          init_done_q, init_done_d;
  logic          usr_done_q, usr_done_d;
  logic          timeout_q, timeout_d;

  logic          fifo_pop;
  logic [15:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  assign usr_ready = !fifo_full;

  sccb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (usr_valid && usr_ready),
    .wdata (usr_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    owner_d     = owner_q;
    call_d      = call_q;
    init_done_d = 1'b0;
    usr_done_d  = 1'b0;
    timeout_d   = timeout_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (init_call) begin
          word_d  = init_data;
          owner_d = 1'b0;
          call_d  = 1'b1;
          cnt_d   = TIMEOUT_LOAD;
          state_d = ISSUE;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_rdata;
          owner_d  = 1'b1;
          call_d   = 1'b1;
          cnt_d    = TIMEOUT_LOAD;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The same counter serves as watchdog here; done wins a tie with expiry.
        if (sccb_done || cnt_q == '0) begin
          call_d      = 1'b0;
          init_done_d = !owner_q;
          usr_done_d  = owner_q;
          if (!sccb_done) timeout_d = 1'b1;
          if (sccb_done && word_q == COM7_RESET) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      owner_q     <= 1'b0;
      call_q      <= 1'b0;
      init_done_q <= 1'b0;
      usr_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      owner_q     <= owner_d;
      call_q      <= call_d;
      init_done_q <= init_done_d;
      usr_done_q  <= usr_done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign sccb_call   = call_q;
  assign sccb_data   = word_q;
  assign owner       = owner_q;
  assign init_done   = init_done_q;
  assign usr_done    = usr_done_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sccb_request_arbiter.sv
// Scoreboard bench for sccb_request_arbiter: stimulus pushes expected words per
// requester; a monitor checks every engine transaction, done pulse and gap.
module tb_sccb_request_arbiter;

  localparam int FD = 4;
  localparam int G  = 16;
  localparam int S  = 300;
  localparam int T  = 600;
  localparam logic [15:0] COM7 = 16'h1280;

  logic        clk;
  logic        rst_n;
  logic        init_call;
  logic [15:0] init_data;
  logic        init_done;
  logic        usr_valid;
  logic [15:0] usr_data;
  logic        usr_ready;
  logic        usr_done;
  logic        sccb_call;
  logic [15:0] sccb_data;
  logic        sccb_done;
  logic        owner;
  logic        busy;
  logic        timeout_err;

  sccb_request_arbiter #(
    .FIFO_DEPTH(FD), .GAP_CYCLES(G), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .init_call(init_call), .init_data(init_data), .init_done(init_done),
    .usr_valid(usr_valid), .usr_data(usr_data), .usr_ready(usr_ready),
    .usr_done(usr_done),
    .sccb_call(sccb_call), .sccb_data(sccb_data), .sccb_done(sccb_done),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  task automatic check_ge(input string name, input int act, input int min_req);
    n_checks++;
    if (act >= min_req) n_pass++;
    else $display("FAIL %s: actual=%0d required>=%0d", name, act, min_req);
  endtask

  // Reference model state: expected word order per requester.
  logic [15:0] exp_init[$];
  logic [15:0] exp_usr[$];
  logic [16:0] issued_log[$];

  // ---------------- engine model ----------------
  int eng_delay = 4;
  bit eng_stall = 0;
  bit eng_mute  = 0;
  bit eng_spur  = 0;
  int eng_cnt   = 0;

  initial begin
    sccb_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        sccb_done = 1'b0; eng_cnt = 0;
      end else if (sccb_done) begin
        sccb_done = 1'b0; eng_cnt = 0;
      end else if (eng_spur && !sccb_call) begin
        sccb_done = 1'b1; eng_spur = 0;
      end else if (sccb_call && !eng_stall && !eng_mute) begin
        eng_cnt++;
        if (eng_cnt >= eng_delay) sccb_done = 1'b1;
      end else if (!sccb_call) begin
        eng_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  bit prev_call = 0, prev_init_call = 0, prev_tmo = 0;
  bit have_fall = 0, stable = 0, cur_owner = 0;
  logic [15:0] cur_word = '0;
  int fall_cyc = 0, min_gap = 0, last_gap = 0, win_start = 0, last_win_len = 0;
  int n_init_done = 0, n_usr_done = 0, n_issued = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_call = 0; prev_init_call = 0; prev_tmo = 0; have_fall = 0;
    end else begin
      if (sccb_call && !prev_call) begin
        n_issued++;
        issued_log.push_back({owner, sccb_data});
        cur_word = sccb_data; cur_owner = owner; stable = 1; win_start = cyc;
        if (have_fall) begin
          last_gap = cyc - fall_cyc;
          check_ge("idle_gap", last_gap, min_gap);
        end
        if (owner) begin
          check("init_priority", {31'b0, prev_init_call}, 0);
          if (exp_usr.size() == 0) check("unexpected_usr_issue", sccb_data, 32'hFFFF_FFFF);
          else check("usr_word_order", sccb_data, exp_usr.pop_front());
        end else begin
          if (exp_init.size() == 0) check("unexpected_init_issue", sccb_data, 32'hFFFF_FFFF);
          else check("init_word", sccb_data, exp_init.pop_front());
        end
      end else if (sccb_call && prev_call) begin
        if (sccb_data !== cur_word || owner !== cur_owner) stable = 0;
      end else if (!sccb_call && prev_call) begin
        last_win_len = cyc - win_start;
        check("window_stable", {31'b0, stable}, 1);
        check("done_owner", {30'b0, init_done, usr_done}, cur_owner ? 32'd1 : 32'd2);
        have_fall = 1; fall_cyc = cyc;
        min_gap = (cur_word == COM7 && !(timeout_err && !prev_tmo)) ? S + G + 1 : G + 1;
      end
      if (!(!sccb_call && prev_call) && (init_done || usr_done))
        check("spurious_done", {30'b0, init_done, usr_done}, 0);
      if (init_done) n_init_done++;
      if (usr_done)  n_usr_done++;
      prev_call = sccb_call; prev_init_call = init_call; prev_tmo = timeout_err;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic init_write(input logic [15:0] w);
    int k;
    init_data = w; init_call = 1'b1; exp_init.push_back(w);
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (init_done) break;
    end
    if (k == 4000) check("init_done_wait", 0, 1);
    @(posedge clk); #1;
    init_call = 1'b0;
  endtask

  task automatic usr_push(input logic [15:0] w);
    int k;
    usr_data = w; usr_valid = 1'b1;
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (usr_ready) break;
    end
    if (k == 4000) begin
      check("usr_accept_wait", 0, 1);
      usr_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      exp_usr.push_back(w);
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 8000; k++) begin
      @(negedge clk);
      if (exp_init.size() == 0 && exp_usr.size() == 0 && !busy && !sccb_call
          && !init_call && !usr_valid) break;
    end
    if (k == 8000) check("wait_idle", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_call();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sccb_call) break;
    end
    if (k == 200) check("wait_call", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b_init, b_usr, b_iss, n;
    logic [15:0] w;
    rst_n = 1'b0; init_call = 1'b0; init_data = '0; usr_valid = 1'b0; usr_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_sccb_call", sccb_call, 0);
    check("rst_sccb_data", sccb_data, 0);
    check("rst_done", {init_done, usr_done}, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_usr_ready", usr_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three init words, engine answers 40 cycles after call.
    eng_delay = 40; b_init = n_init_done;
    init_write(16'h1180); init_write(16'h3a04); init_write(16'h1200);
    wait_idle();
    check("s1_init_done_count", n_init_done - b_init, 3);
    check("s1_window_len", last_win_len, 40);
    check("s1_gap_back_to_back", last_gap, G + 1);

    // COM7 soft reset holds off the next transaction by settle + gap.
    eng_delay = 5;
    init_write(COM7); init_write(16'h1100);
    wait_idle();
    check("s2_settle_gap", last_gap, S + G + 1);

    // Simultaneous init and user requests: init first.
    b_usr = n_usr_done;
    fork
      init_write(16'h0c08);
      begin usr_push(16'h7100); usr_valid = 1'b0; end
    join
    wait_idle();
    n = issued_log.size();
    check("s3_first", issued_log[n-2], {1'b0, 16'h0c08});
    check("s3_second", issued_log[n-1], {1'b1, 16'h7100});
    check("s3_usr_done", n_usr_done - b_usr, 1);

    // Engine stalled: queue fills after four, fifth waits, order preserved.
    eng_delay = 3; eng_stall = 1; b_usr = n_usr_done;
    fork init_write(16'h1300); join_none
    wait_call();
    for (int i = 0; i < 4; i++) usr_push(16'h2000 + 16'(i));
    check("s4_ready_low_after_4", usr_ready, 0);
    fork begin usr_push(16'h2004); usr_valid = 1'b0; end join_none
    repeat (10) @(posedge clk); #1;
    check("s4_fifth_held_ready", usr_ready, 0);
    check("s4_fifth_not_accepted", exp_usr.size(), 4);
    eng_stall = 0;
    wait_idle();
    check("s4_usr_done_count", n_usr_done - b_usr, 5);
    check("s4_no_timeout", timeout_err, 0);

    // Stray sccb_done while idle and during the gap is ignored.
    b_usr = n_usr_done; b_iss = n_issued;
    eng_spur = 1;
    repeat (5) @(posedge clk); #1;
    check("s5_idle_busy", busy, 0);
    usr_push(16'h4455); usr_valid = 1'b0;
    while (!usr_done) @(negedge clk);
    @(posedge clk); #1;
    eng_spur = 1;
    wait_idle();
    check("s5_usr_done", n_usr_done - b_usr, 1);
    check("s5_issued", n_issued - b_iss, 1);
    check("s5_no_timeout", timeout_err, 0);

    // Randomized traffic from both requesters.
    b_usr = n_usr_done; b_init = n_init_done;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int d;
          eng_delay = $urandom_range(1, 8);
          w = 16'($urandom);
          if (w == COM7) w = w ^ 16'h0001;
          usr_push(w);
          d = $urandom_range(0, 3);
          if (d != 0) begin
            usr_valid = 1'b0;
            repeat (d) @(posedge clk); #1;
          end
        end
        usr_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(20, 120)) @(posedge clk); #1;
          w = 16'($urandom);
          if (w == COM7) w = w ^ 16'h0001;
          init_write(w);
        end
      end
    join
    wait_idle();
    check("rand_usr_done", n_usr_done - b_usr, 30);
    check("rand_init_done", n_init_done - b_init, 6);

    // Engine never answers: watchdog fires, next request still proceeds.
    eng_mute = 1; b_init = n_init_done;
    init_write(16'h5a5a);
    check("to_flag", timeout_err, 1);
    check("to_window_len", last_win_len, T);
    check("to_init_done", n_init_done - b_init, 1);
    eng_mute = 0; b_usr = n_usr_done;
    usr_push(16'h6600); usr_valid = 1'b0;
    wait_idle();
    check("to_next_done", n_usr_done - b_usr, 1);
    check("to_flag_sticky", timeout_err, 1);

    // Reset in the middle of an issue abandons everything.
    eng_stall = 1;
    usr_push(16'h3311); usr_push(16'h3322); usr_push(16'h3333); usr_valid = 1'b0;
    if (!sccb_call) wait_call();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_call", sccb_call, 0);
    check("mid_rst_ready", usr_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout_cleared", timeout_err, 0);
    exp_usr.delete();
    b_usr = n_usr_done; b_init = n_init_done; b_iss = n_issued;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; eng_stall = 0;
    repeat (40) @(posedge clk); #1;
    check("post_rst_no_issue", n_issued - b_iss, 0);
    check("post_rst_no_done", (n_usr_done - b_usr) + (n_init_done - b_init), 0);
    check("post_rst_ready", usr_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sccb_request_arbiter.md
SCCB_REQUEST_ARBITER -- requirements
Module: sccb_request_arbiter

Interface
REQ-001 Parameters, as name, default, meaning; every parameter SHALL be overridable at instantiation:
- FIFO_DEPTH, 4, user write queue depth (power of two).
- GAP_CYCLES, 16, idle cycles between SCCB transactions (minimum 2).
- SETTLE_CYCLES, 50000, hold-off after a COM7 soft reset write (1 ms at 50 MHz).
- TIMEOUT_CYCLES, 100000, watchdog limit on the sccb_done wait.
REQ-002 Ports, as name, direction, width, meaning; the module SHALL provide exactly these ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- init_call, in, 1, init table requester holds high to request a write.
- init_data, in, 16, {reg addr, value}; sampled when init_call is granted.
- init_done, out, 1, one-cycle pulse when the init write completes.
- usr_valid, in, 1, runtime write request.
- usr_data, in, 16, {reg addr, value}.
- usr_ready, out, 1, queue can accept a write.
- usr_done, out, 1, one-cycle pulse when a queued write completes.
- sccb_call, out, 1, level request to the SCCB write engine.
- sccb_data, out, 16, word presented to the engine.
- sccb_done, in, 1, one-cycle completion pulse from the engine.
- owner, out, 1, requester of the current transaction: 0 = init, 1 = user.
- busy, out, 1, high whenever the state is not IDLE.
- timeout_err, out, 1, sticky watchdog flag.

Function
REQ-003 The state machine SHALL have four states: IDLE, ISSUE, SETTLE and GAP.
REQ-004 In IDLE, if init_call=1, the block SHALL latch init_data, set owner=0 and go to ISSUE on the next cycle.
REQ-005 In IDLE, if init_call=0 and the queue is non-empty, the block SHALL pop the head word, set owner=1 and go to ISSUE; init always wins when both requests are present in the same cycle.
REQ-006 Outside IDLE, init_call SHALL be ignored, so a requester's stale call is never re-granted; granted transactions are never preempted.
REQ-007 In ISSUE, sccb_call SHALL be 1 and sccb_data SHALL equal the latched word; sccb_call and sccb_data are registered outputs.
REQ-008 When sccb_done=1 in ISSUE, the block SHALL:
- drop sccb_call on the next cycle;
- pulse init_done (owner=0) or usr_done (owner=1) for exactly one cycle;
- go to SETTLE if the latched word equals 16'h1280, otherwise go to GAP.
REQ-009 SETTLE SHALL last exactly SETTLE_CYCLES cycles and GAP exactly GAP_CYCLES cycles, each counted by a single down-counter; SETTLE goes to GAP and GAP goes to IDLE.
REQ-010 If sccb_done has not arrived after TIMEOUT_CYCLES in ISSUE, the block SHALL set timeout_err=1, drop sccb_call, pulse the owner's done signal and go to GAP.
REQ-011 sccb_done arriving outside ISSUE SHALL be ignored.
REQ-012 The user queue SHALL be a FIFO of FIFO_DEPTH 16-bit entries with a count of width log2(FIFO_DEPTH)+1.
REQ-013 The block SHALL assert usr_ready = !full combinationally and SHALL push when usr_valid && usr_ready.
REQ-014 A push and a pop in the same cycle SHALL leave the count unchanged; when full, a push is refused even in a popping cycle.
REQ-015 Writes from the queue SHALL be issued in arrival order, with no loss and no duplication.

Reset
REQ-016 While rst_n=0, the block SHALL drive:
- state IDLE, all counters 0, queue empty;
- sccb_call=0, sccb_data=16'h0000;
- init_done=0, usr_done=0, owner=0, busy=0, timeout_err=0;
- usr_ready=1.
REQ-017 A reset mid-transaction SHALL abandon it with no done pulse; only reset clears timeout_err.

Structure
REQ-018 The shared package sccb_arb_pkg SHALL hold the state encoding, COM7_RESET=16'h1280 and the parameter defaults.
REQ-019 The queue SHALL be a single sub-module, sccb_req_fifo, instantiated once.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Three init words 16'h1180, 16'h3a04, 16'h1200 through a model engine with done 40 cycles after call -> three sccb_call windows with matching sccb_data; three init_done pulses; windows separated by ≥16 idle cycles.
- Init word 16'h1280 -> next sccb_call no earlier than 50000+16 cycles after its sccb_done.
- init_call and usr_valid (16'h7100) rising together -> init word issued first, then 16'h7100 with owner=1, then usr_done.
- Five back-to-back user writes with the engine stalled -> usr_ready falls after the 4th accepted; the 5th is held; all issue in order once the engine resumes.
- Engine never responds -> timeout_err=1 after 100000 cycles; owner's done pulses; next request proceeds.
- rst_n asserted mid-ISSUE -> sccb_call=0 immediately; no done pulse; queue empty; usr_ready=1.
